q3c_state_sequencer: RTL and testbench

Registered state sequencer for the Q3c five-state FSM. It holds the 3-bit state register, applies the Q3c transition function on each qualified input sample, and drives the current state `y` to downstream next-state/output logic. It also produces the Moore output `z`, a z-entry pulse, a saturating z-entry counter and a sticky illegal-state flag. It sits directly upstream of the combinational Q3c next-state logic.

---
 rtl/q3c_state_sequencer.sv | 116 +++++++++++
 tb/tb_q3c_state_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/q3c_state_sequencer.sv
// Registered state sequencer for the Q3c five-state FSM with z-entry tracking.
// Optional state injection port (load_en/load_state) enabled by Q3C_STATE_INJECT_EN.
module q3c_state_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    input  logic             x,
    input  logic             clear,
`ifdef Q3C_STATE_INJECT_EN
    input  logic             load_en,
    input  logic [2:0]       load_state,
`endif
    output logic [2:0]       y,
    output logic             z,
    output logic             z_rise,
    output logic [CNT_W-1:0] z_count,
    output logic             illegal_err
);

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_B = 3'd1;
    localparam logic [2:0] ST_C = 3'd2;
    localparam logic [2:0] ST_D = 3'd3;
    localparam logic [2:0] ST_E = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       state_r;
    logic [2:0]       y_next_s;
    logic             z_s;
    logic             z_entry_s;
    logic             illegal_s;
    logic             z_rise_r;
    logic [CNT_W-1:0] z_count_r;
    logic             illegal_err_r;

    function automatic logic in_de(input logic [2:0] s);
        return (s == ST_D) || (s == ST_E);
    endfunction

    // Unencoded values 5..7 fall through to A so recovery takes one qualified sample.
    function automatic logic [2:0] q3c_next(input logic [2:0] s, input logic xi);
        logic [2:0] n;
        case (s)
            ST_A:    n = xi ? ST_B : ST_A;
            ST_B:    n = xi ? ST_E : ST_B;
            ST_C:    n = xi ? ST_B : ST_C;
            ST_D:    n = xi ? ST_C : ST_B;
            ST_E:    n = xi ? ST_E : ST_D;
            default: n = ST_A;
        endcase
        return n;
    endfunction

    // State, pulse, counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_A;
            z_rise_r      <= 1'b0;
            z_count_r     <= '0;
            illegal_err_r <= 1'b0;
        end else begin
            state_r  <= y_next_s;
            z_rise_r <= z_entry_s;
            if (clear) begin
                z_count_r <= '0;
            end else if (z_entry_s && (z_count_r != CNT_MAX)) begin
                z_count_r <= z_count_r + CNT_W'(1);
            end else begin
                z_count_r <= z_count_r;
            end
            if (clear) begin
                illegal_err_r <= 1'b0;
            end else if (illegal_s) begin
                illegal_err_r <= 1'b1;
            end else begin
                illegal_err_r <= illegal_err_r;
            end
        end
    end

    // Next-state selection: injection beats a qualified sample, otherwise hold.
    always_comb begin
        y_next_s = state_r;
`ifdef Q3C_STATE_INJECT_EN
        if (load_en) begin
            y_next_s = load_state;
        end else if (x_valid) begin
            y_next_s = q3c_next(state_r, x);
        end else begin
            y_next_s = state_r;
        end
`else
        if (x_valid) begin
            y_next_s = q3c_next(state_r, x);
        end else begin
            y_next_s = state_r;
        end
`endif
    end

    // Moore output and per-edge event decode from the current state.
    always_comb begin
        z_s       = in_de(state_r);
        z_entry_s = in_de(y_next_s) && !in_de(state_r);
        illegal_s = (state_r > ST_E);
    end

    assign y           = state_r;
    assign z           = z_s;
    assign z_rise      = z_rise_r;
    assign z_count     = z_count_r;
    assign illegal_err = illegal_err_r;

endmodule

// File: tb/tb_q3c_state_sequencer.sv
// Self-checking bench for q3c_state_sequencer: spec-level model checked every cycle
// plus directed literal expectations; two instances (CNT_W=8 and CNT_W=2).
module tb_q3c_state_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x_valid;
    logic       x;
    logic       clear;
    logic       load_en;
    logic [2:0] load_state;

    logic [2:0] y1, y2;
    logic       z1, z2, rise1, rise2, err1, err2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    // Directed literal expectations; -1 means "not checked this cycle".
    int d_y = -1, d_z = -1, d_r = -1, d_c = -1, d_c2 = -1, d_e = -1;

    always #5 clk = ~clk;

    q3c_state_sequencer #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .clear(clear),
`ifdef Q3C_STATE_INJECT_EN
        .load_en(load_en), .load_state(load_state),
`endif
        .y(y1), .z(z1), .z_rise(rise1), .z_count(cnt1), .illegal_err(err1)
    );

    q3c_state_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .clear(clear),
`ifdef Q3C_STATE_INJECT_EN
        .load_en(load_en), .load_state(load_state),
`endif
        .y(y2), .z(z2), .z_rise(rise2), .z_count(cnt2), .illegal_err(err2)
    );

    // ---------------- behavioural model ----------------
    function automatic bit is_z(input int s);
        return (s == 3) || (s == 4);
    endfunction

    function automatic int mnext(input int s, input bit xv, input bit xi, input bit ld, input int ls);
        if (ld) return ls;
        if (!xv) return s;
        case (s)
            0: return xi ? 1 : 0;  // A
            1: return xi ? 4 : 1;  // B
            2: return xi ? 1 : 2;  // C
            3: return xi ? 2 : 1;  // D
            4: return xi ? 4 : 3;  // E
            default: return 0;
        endcase
    endfunction

    int m_y, m_cnt8, m_cnt2;
    bit m_rise, m_err, m_entry;

    assign m_entry = is_z(mnext(m_y, x_valid, x, load_en, int'(load_state))) && !is_z(m_y);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y <= 0; m_rise <= 1'b0; m_cnt8 <= 0; m_cnt2 <= 0; m_err <= 1'b0;
        end else begin
            m_y    <= mnext(m_y, x_valid, x, load_en, int'(load_state));
            m_rise <= m_entry;
            m_cnt8 <= clear ? 0 : ((m_entry && m_cnt8 < 255) ? m_cnt8 + 1 : m_cnt8);
            m_cnt2 <= clear ? 0 : ((m_entry && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2);
            m_err  <= clear ? 1'b0 : (m_err || (m_y >= 5));
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("y",       int'(y1),    m_y);
        chk("y_w2",    int'(y2),    m_y);
        chk("z",       int'(z1),    int'(is_z(m_y)));
        chk("z_w2",    int'(z2),    int'(is_z(m_y)));
        chk("z_rise",  int'(rise1), int'(m_rise));
        chk("z_rise2", int'(rise2), int'(m_rise));
        chk("z_count", int'(cnt1),  m_cnt8);
        chk("z_cnt2",  int'(cnt2),  m_cnt2);
        chk("ill_err", int'(err1),  int'(m_err));
        chk("ill_err2",int'(err2),  int'(m_err));
        if (d_y  >= 0) chk("lit_y",      int'(y1),    d_y);
        if (d_z  >= 0) chk("lit_z",      int'(z1),    d_z);
        if (d_r  >= 0) chk("lit_z_rise", int'(rise1), d_r);
        if (d_c  >= 0) chk("lit_count",  int'(cnt1),  d_c);
        if (d_c2 >= 0) chk("lit_count2", int'(cnt2),  d_c2);
        if (d_e  >= 0) chk("lit_err",    int'(err1),  d_e);
    end

    // ---------------- stimulus ----------------
    task automatic expect_lit(input int ey, input int ez, input int er,
                              input int ec, input int ec2, input int ee);
        d_y = ey; d_z = ez; d_r = er; d_c = ec; d_c2 = ec2; d_e = ee;
    endtask

    // Apply one sample shortly after the falling edge; clears prior expectations.
    task automatic step(input bit xv, input bit xi, input bit cl);
        @(negedge clk);
        #1;
        expect_lit(-1, -1, -1, -1, -1, -1);
        x_valid = xv; x = xi; clear = cl; load_en = 1'b0; load_state = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0; x_valid = 1'b0; x = 1'b0; clear = 1'b0;
        load_en = 1'b0; load_state = 3'd0;
        expect_lit(0, 0, 0, 0, 0, 0);

        step(1'b0, 1'b0, 1'b0); rst_n = 1'b1; expect_lit(0, 0, 0, 0, 0, 0);

        // Walk x = 1,1,0,0,1
        step(1'b1, 1'b1, 1'b0); expect_lit(1, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0); expect_lit(4, 1, 1, 1, 1, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(3, 1, 0, 1, 1, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(1, 0, 0, 1, 1, 0);
        step(1'b1, 1'b1, 1'b0); expect_lit(4, 1, 1, 2, 2, 0);

        // Back to B, then gating
        step(1'b1, 1'b0, 1'b0); expect_lit(3, 1, 0, 2, 2, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(1, 0, 0, 2, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0); expect_lit(1, 0, 0, 2, 2, 0);
        end
        step(1'b1, 1'b1, 1'b0); expect_lit(4, 1, 1, 3, 3, 0);

        // Saturation of the 2-bit counter: E->D->B->E loops
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0); expect_lit(3, 1, 0, 3 + i, 3, 0);
            step(1'b1, 1'b0, 1'b0); expect_lit(1, 0, 0, 3 + i, 3, 0);
            step(1'b1, 1'b1, 1'b0); expect_lit(4, 1, 1, 4 + i, 3, 0);
        end

        // Clear collides with entry into E
        step(1'b1, 1'b0, 1'b0); expect_lit(3, 1, 0, 5, 3, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(1, 0, 0, 5, 3, 0);
        step(1'b1, 1'b1, 1'b1); expect_lit(4, 1, 1, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(3, 1, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0); expect_lit(1, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0); expect_lit(4, 1, 1, 1, 1, 0);
        step(1'b0, 1'b0, 1'b0); expect_lit(4, 1, 0, 1, 1, 0);

        // Asynchronous reset mid-cycle, checked before any further rising edge
        step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_lit(0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0); rst_n = 1'b1; expect_lit(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0); expect_lit(0, 0, 0, 0, 0, 0);
        end

`ifdef Q3C_STATE_INJECT_EN
        step(1'b1, 1'b1, 1'b0); load_en = 1'b1; load_state = 3'd6;
        expect_lit(6, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0); expect_lit(0, 0, 0, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0); expect_lit(0, 0, 0, 0, 0, 1);
        step(1'b0, 1'b0, 1'b1); expect_lit(0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0); load_en = 1'b1; load_state = 3'd3;
        expect_lit(3, 1, 1, 1, 1, 0);
        step(1'b0, 1'b0, 1'b0); expect_lit(3, 1, 0, 1, 1, 0);
`endif

        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
